// File: rtl/score_disp_pkg.sv
// score_disp_pkg: select codes, mode encodings and FSM states for score_display_ctrl
package score_disp_pkg;
  localparam logic [4:0] SEG_DASH  = 5'd16;
  localparam logic [4:0] SEG_A     = 5'd22;
  localparam logic [4:0] SEG_B     = 5'd23;
  localparam logic [4:0] SEG_C     = 5'd24;
  localparam logic [4:0] SEG_D     = 5'd25;
  localparam logic [4:0] SEG_E     = 5'd26;
  localparam logic [4:0] SEG_F     = 5'd27;
  localparam logic [4:0] SEG_BLANK = 5'd31;
  localparam logic [1:0] MODE_SCORE = 2'd0;
  localparam logic [1:0] MODE_DASH  = 2'd1;
  localparam logic [1:0] MODE_CHASE = 2'd2;
  localparam logic [1:0] MODE_BLANK = 2'd3;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one shift per cycle for SCORE_W cycles
module bin2bcd_seq #(
  parameter int DIGITS  = 4,
  parameter int SCORE_W = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int W  = 4*DIGITS + SCORE_W;
  localparam int CW = $clog2(SCORE_W + 1);
  logic [W-1:0] work, adj;
  logic [CW-1:0] cnt;
  logic run;
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++)
      if (work[SCORE_W+4*i +: 4] >= 4'd5) adj[SCORE_W+4*i +: 4] = work[SCORE_W+4*i +: 4] + 4'd3;
  end
  assign done = run && cnt == CW'(SCORE_W - 1);
  assign bcd  = work[W-1 -: 4*DIGITS];
  always_ff @(posedge clk)
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      work <= W'(bin);
      cnt  <= '0;
      run  <= 1'b1;
    end else if (run) begin
      work <= {adj[W-2:0], 1'b0};
      cnt  <= cnt + 1'b1;
      run  <= !done;
    end
endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: score BCD conversion and HEX select-code driver; LEAD_ZERO_BLANK_EN blanks leading zeros
module score_display_ctrl
  import score_disp_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCORE_W   = 14,
  parameter int CHASE_DIV = 5000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SCORE_W-1:0]    score_in,
  input  logic                  load,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  valid,
  output logic [5*DIGITS-1:0]   sel_out
);
  localparam int SW = $clog2(2*DIGITS + 4);
  localparam int PW = $clog2(CHASE_DIV + 1);
  localparam logic [31:0] LIMIT = 32'(10**DIGITS);
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [5*DIGITS-1:0] RST_SEL = {{(DIGITS-1){SEG_BLANK}}, 5'd0};
`else
  localparam logic [5*DIGITS-1:0] RST_SEL = '0;
`endif
  state_t state, nxt;
  logic [SCORE_W-1:0] pend, src;
  logic pend_v, start, done, sat, zb;
  logic [4*DIGITS-1:0] bcd, result;
  logic [SW-1:0] step;
  logic [PW-1:0] pre;
  logic [5*DIGITS-1:0] nxt_sel;
  logic [4:0] ccode;
  int p, cdig;

  bin2bcd_seq #(.DIGITS(DIGITS), .SCORE_W(SCORE_W)) u_b2b (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(src), .done(done), .bcd(bcd)
  );

  always_comb begin
    start = (state == IDLE && load) || (state == COMMIT && (load || pend_v));
    src   = (state == COMMIT && !load) ? pend : score_in;
    nxt   = state == IDLE ? (load ? CONV : IDLE) : state == CONV ? (done ? COMMIT : CONV) : (start ? CONV : IDLE);
  end

  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  always_ff @(posedge clk)
    if (!rst_n) begin
      pend   <= '0;
      pend_v <= 1'b0;
      sat    <= 1'b0;
      result <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      busy  <= state != IDLE;
      valid <= state == COMMIT;
      if (state == COMMIT) result <= sat ? {DIGITS{4'd9}} : bcd;
      if (start) sat <= 32'(src) >= LIMIT;
      if (state == CONV && load) begin
        pend   <= score_in;
        pend_v <= 1'b1;
      end else if (state == COMMIT) pend_v <= 1'b0;
    end

  // held at zero outside chase mode so every entry restarts the animation
  always_ff @(posedge clk)
    if (!rst_n || mode != MODE_CHASE) begin
      pre  <= '0;
      step <= '0;
    end else if (pre == PW'(CHASE_DIV - 1)) begin
      pre  <= '0;
      step <= step == SW'(2*DIGITS + 3) ? '0 : step + 1'b1;
    end else pre <= pre + 1'b1;

  always_comb begin
    p     = int'(step);
    cdig  = p < DIGITS ? DIGITS-1-p : p < DIGITS+2 ? 0 : p < 2*DIGITS+2 ? p-DIGITS-2 : DIGITS-1;
    ccode = p < DIGITS ? SEG_A : p == DIGITS ? SEG_B : p == DIGITS+1 ? SEG_C :
            p < 2*DIGITS+2 ? SEG_D : p == 2*DIGITS+2 ? SEG_E : SEG_F;
  end

  always_comb begin
    nxt_sel = '0;
    zb      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef LEAD_ZERO_BLANK_EN
      zb = i > 0 && (result >> (4*i)) == '0;
`else
      zb = 1'b0;
`endif
      nxt_sel[5*i +: 5] = mode == MODE_DASH ? SEG_DASH : mode == MODE_BLANK ? SEG_BLANK :
                          mode == MODE_CHASE ? (i == cdig ? ccode : SEG_BLANK) :
                          zb ? SEG_BLANK : {1'b0, result[4*i +: 4]};
    end
  end

  always_ff @(posedge clk)
    if (!rst_n) sel_out <= RST_SEL;
    else sel_out <= nxt_sel;
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed and randomized checks of score_display_ctrl against a decimal model
module tb_score_display_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, busy, valid;
  logic [13:0] score_in = '0;
  logic [1:0] mode = 2'd0;
  logic [19:0] sel_out;
  int checks = 0, failures = 0;
  int pd[12], pc[12];

  score_display_ctrl #(.DIGITS(4), .SCORE_W(14), .CHASE_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .score_in(score_in), .load(load), .mode(mode),
    .busy(busy), .valid(valid), .sel_out(sel_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] exp_score(int v);
    int s, d;
    bit seen, lzb;
    logic [4:0] c;
    logic [19:0] r;
    s = v >= 10000 ? 9999 : v;
    seen = 0;
    lzb = 0;
    r = '0;
`ifdef LEAD_ZERO_BLANK_EN
    lzb = 1;
`endif
    for (int i = 3; i >= 0; i--) begin
      d = (s / (10**i)) % 10;
      c = 5'(d);
      if (d != 0 || i == 0) seen = 1;
      if (lzb && !seen) c = 5'd31;
      r[5*i +: 5] = c;
    end
    return r;
  endfunction

  function automatic logic [19:0] all_code(logic [4:0] c);
    return {4{c}};
  endfunction

  task automatic do_conv(int v, string tag, logic [19:0] exp_sel);
    int lat;
    bit busy_ok;
    score_in = 14'(v);
    load = 1'b1;
    tick;
    load = 1'b0;
    lat = 0;
    busy_ok = 1;
    while (lat < 40) begin
      tick;
      lat++;
      if (!busy) busy_ok = 0;
      if (valid) break;
    end
    chk({tag, "_lat"}, lat, 15);
    chk({tag, "_busy"}, 32'(busy_ok), 1);
    tick;
    chk({tag, "_sel"}, sel_out, exp_sel);
    chk({tag, "_vpulse"}, valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic back2back(int a, int b, int c, string tag);
    int pulses, first, second, busy_low, saw_b;
    logic [19:0] sel_after_first;
    score_in = 14'(a); load = 1'b1; tick; load = 1'b0;
    tick; tick;
    score_in = 14'(b); load = 1'b1; tick; load = 1'b0;
    tick;
    score_in = 14'(c); load = 1'b1; tick; load = 1'b0;
    pulses = 0; first = -1; second = -1; busy_low = 0; saw_b = 0;
    sel_after_first = '0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (k == first + 1 && first >= 0) sel_after_first = sel_out;
      if (valid) begin
        pulses++;
        if (first < 0) first = k; else second = k;
      end
      if (first >= 0 && second < 0 && !busy) busy_low++;
      if (sel_out == exp_score(b) && exp_score(b) != exp_score(a) && exp_score(b) != exp_score(c)) saw_b = 1;
    end
    chk({tag, "_pulses"}, pulses, 2);
    chk({tag, "_gap"}, second - first, 15);
    chk({tag, "_busy_held"}, busy_low, 0);
    chk({tag, "_first_sel"}, sel_after_first, exp_score(a));
    chk({tag, "_final_sel"}, sel_out, exp_score(c));
    chk({tag, "_dropped"}, saw_b, 0);
  endtask

  initial begin
    int n, v;
    logic [19:0] e;
    n = 0;
    for (int d = 3; d >= 0; d--) begin pd[n] = d; pc[n] = 22; n++; end
    pd[n] = 0; pc[n] = 23; n++;
    pd[n] = 0; pc[n] = 24; n++;
    for (int d = 0; d < 4; d++) begin pd[n] = d; pc[n] = 25; n++; end
    pd[n] = 3; pc[n] = 26; n++;
    pd[n] = 3; pc[n] = 27; n++;

    score_in = 14'd1234;
    load = 1'b1;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_sel", sel_out, exp_score(0));
    load = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("rst_wins_load", busy, 0);

    do_conv(1234, "s1234", exp_score(1234));
    do_conv(7, "s7", exp_score(7));
    do_conv(0, "s0", exp_score(0));
    do_conv(9999, "s9999", exp_score(9999));
    do_conv(10000, "s10000", exp_score(10000));
    do_conv(12000, "s12000", exp_score(12000));
    do_conv(16383, "s16383", exp_score(16383));
    for (int k = 0; k < 8; k++) begin
      v = int'($urandom_range(0, 16383));
      do_conv(v, $sformatf("rnd%0d_%0d", k, v), exp_score(v));
    end

    back2back(42, 100, 555, "b2b");
    back2back(int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)), "b2b_rnd");

    mode = 2'd1;
    tick;
    chk("dash", sel_out, all_code(5'd16));
    mode = 2'd2;
    for (int k = 0; k < 28; k++) begin
      tick;
      e = all_code(5'd31);
      e[5*pd[(k/2)%12] +: 5] = 5'(pc[(k/2)%12]);
      chk($sformatf("chase%0d", k), sel_out, e);
    end
    mode = 2'd3;
    tick;
    chk("blank", sel_out, all_code(5'd31));
    mode = 2'd2;
    tick;
    e = all_code(5'd31);
    e[15 +: 5] = 5'd22;
    chk("chase_restart", sel_out, e);

    v = int'($urandom_range(0, 9999));
    mode = 2'd3;
    do_conv(v, "mode_nostall", all_code(5'd31));
    mode = 2'd0;
    tick;
    chk("mode_back", sel_out, exp_score(v));

    score_in = 14'd3333;
    load = 1'b1;
    tick;
    load = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_sel", sel_out, exp_score(0));
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 25; k++) begin
      tick;
      if (valid || busy) n++;
    end
    chk("abort_quiet", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
